// File: rtl/alu_div.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the W forms.
// Optional feature macro: DIV_SPECIAL_BYPASS_EN (divide-by-zero / overflow retire without CALC).
module alu_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic        div_signed_i,
  input  logic        rem_sel_i,
  input  logic        div32_valid_i,
  input  logic [63:0] dividend_i,
  input  logic [63:0] divisor_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] div_out_o,
  output logic        busy_o
);
  localparam int XLEN = 64;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] rem_r;
  logic [XLEN-1:0] quo_r;
  logic [XLEN-1:0] dvsr_r;
  logic [6:0]      cnt_r;
  logic            rem_sel_r;
  logic            w_r;
  logic            neg_quo_r;
  logic            neg_rem_r;
`ifndef DIV_SPECIAL_BYPASS_EN
  logic            special_r;
  logic [XLEN-1:0] spec_res_r;
`endif

  // Operand preparation, evaluated against the live inputs at the accept edge.
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_abs, b_abs, a_ext, a_load, b_load;
  logic            in_div_zero, in_ovf, in_special;
  logic [XLEN-1:0] spec_res;

  always_comb begin
    // NOTE: every signal driven here is assigned on every path, so no latch is inferred.
    a_neg = div_signed_i & (div32_valid_i ? dividend_i[31] : dividend_i[63]);
    b_neg = div_signed_i & (div32_valid_i ? divisor_i[31]  : divisor_i[63]);
    a_abs = a_neg ? -dividend_i : dividend_i;
    b_abs = b_neg ? -divisor_i  : divisor_i;
    a_ext = div32_valid_i ? {{32{dividend_i[31]}}, dividend_i[31:0]} : dividend_i;
    if (div32_valid_i) begin
      // W dividend sits in the upper half so that 32 shifts move all of it into rem.
      a_load      = {a_abs[31:0], 32'b0};
      b_load      = {32'b0, b_abs[31:0]};
      in_div_zero = (divisor_i[31:0] == 32'b0);
      in_ovf      = div_signed_i & (dividend_i[31:0] == 32'h8000_0000)
                                 & (divisor_i[31:0] == 32'hFFFF_FFFF);
    end else begin
      a_load      = a_abs;
      b_load      = b_abs;
      in_div_zero = (divisor_i == '0);
      in_ovf      = div_signed_i & (dividend_i == {1'b1, {(XLEN-1){1'b0}}})
                                 & (divisor_i == '1);
    end
    in_special = in_div_zero | in_ovf;
    if (in_div_zero) spec_res = rem_sel_i ? a_ext : '1;
    else             spec_res = rem_sel_i ? '0 : a_ext;
  end

  // One restoring step: shift {rem,quo} left, subtract the divisor when it fits.
  logic [XLEN:0]   shifted, diff;
  logic [XLEN-1:0] rem_step, quo_step;

  always_comb begin
    shifted = {rem_r, quo_r[XLEN-1]};
    diff    = shifted - {1'b0, dvsr_r};
    if (!diff[XLEN]) begin
      rem_step = diff[XLEN-1:0];
      quo_step = {quo_r[XLEN-2:0], 1'b1};
    end else begin
      rem_step = shifted[XLEN-1:0];
      quo_step = {quo_r[XLEN-2:0], 1'b0};
    end
  end

  // Sign fix of the finished magnitudes; W results re-extend from bit 31.
  logic [XLEN-1:0] q_fix, r_fix, sel_fix, fix_res;

  always_comb begin
    q_fix   = neg_quo_r ? -quo_r : quo_r;
    r_fix   = neg_rem_r ? -rem_r : rem_r;
    sel_fix = rem_sel_r ? r_fix : q_fix;
    fix_res = w_r ? {{32{sel_fix[31]}}, sel_fix[31:0]} : sel_fix;
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      rem_r     <= '0;
      quo_r     <= '0;
      dvsr_r    <= '0;
      cnt_r     <= '0;
      rem_sel_r <= 1'b0;
      w_r       <= 1'b0;
      neg_quo_r <= 1'b0;
      neg_rem_r <= 1'b0;
      div_out_o <= '0;
`ifndef DIV_SPECIAL_BYPASS_EN
      special_r  <= 1'b0;
      spec_res_r <= '0;
`endif
    end else if (flush_i) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid_i) begin
            rem_r     <= '0;
            quo_r     <= a_load;
            dvsr_r    <= b_load;
            cnt_r     <= div32_valid_i ? 7'd32 : 7'd64;
            rem_sel_r <= rem_sel_i;
            w_r       <= div32_valid_i;
            neg_quo_r <= a_neg ^ b_neg;
            neg_rem_r <= a_neg;
`ifdef DIV_SPECIAL_BYPASS_EN
            if (in_special) begin
              state     <= DONE;
              div_out_o <= spec_res;
            end else begin
              state <= CALC;
            end
`else
            special_r  <= in_special;
            spec_res_r <= spec_res;
            state      <= CALC;
`endif
          end
        end
        CALC: begin
          if (cnt_r == 7'd0) begin
            state <= DONE;
`ifdef DIV_SPECIAL_BYPASS_EN
            div_out_o <= fix_res;
`else
            div_out_o <= special_r ? spec_res_r : fix_res;
`endif
          end else begin
            rem_r <= rem_step;
            quo_r <= quo_step;
            cnt_r <= cnt_r - 7'd1;
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign busy_o      = (state != IDLE);

endmodule
